// File: rtl/pipe_stage_buffer.sv
// Pipeline-stage register with valid/ready handshake and a two-entry skid buffer.
// Supports synchronous flush and a saturating count of upstream-blocked cycles.
module pipe_stage_buffer #(
    parameter int PC_W   = 32,
    parameter int DATA_W = 64,
    parameter int CTRL_W = 9,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              flush,
    input  logic              stall_clr,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t              state_q, state_d;
    logic [PC_W-1:0]     main_pc_q, skid_pc_q;
    logic [DATA_W-1:0]   main_data_q, skid_data_q;
    logic [CTRL_W-1:0]   main_ctrl_q, skid_ctrl_q;
    logic                in_ready_q, out_valid_q;
    logic [1:0]          occ_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                accept, deliver;

    assign accept  = in_valid & in_ready_q;
    assign deliver = out_valid_q & out_ready;

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY:   if (accept) state_d = ONE;
                ONE: begin
                    if (accept && !deliver)      state_d = FULL;
                    else if (!accept && deliver) state_d = EMPTY;
                end
                FULL:    if (deliver) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    // Counter saturates at all-ones; clear beats increment.
    always_comb begin
        cnt_d = cnt_q;
        if (stall_clr)
            cnt_d = '0;
        else if (in_valid && !in_ready_q && !flush && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= EMPTY;
            main_pc_q   <= '0;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_pc_q   <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            occ_q       <= 2'd0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= (state_d != FULL);
            out_valid_q <= (state_d != EMPTY);
            case (state_d)
                EMPTY:   occ_q <= 2'd0;
                ONE:     occ_q <= 2'd1;
                FULL:    occ_q <= 2'd2;
                default: occ_q <= 2'd0;
            endcase

            // An empty stage presents a NOP bubble with all control deasserted.
            if (state_d == EMPTY) begin
                main_pc_q   <= '0;
                main_data_q <= '0;
                main_ctrl_q <= '0;
            end else if ((state_q == EMPTY && accept) ||
                         (state_q == ONE && accept && deliver)) begin
                main_pc_q   <= in_pc;
                main_data_q <= in_data;
                main_ctrl_q <= in_ctrl;
            end else if (state_q == FULL && deliver) begin
                main_pc_q   <= skid_pc_q;
                main_data_q <= skid_data_q;
                main_ctrl_q <= skid_ctrl_q;
            end

            if (flush || (state_q == FULL && deliver)) begin
                skid_pc_q   <= '0;
                skid_data_q <= '0;
                skid_ctrl_q <= '0;
            end else if (state_q == ONE && accept && !deliver) begin
                skid_pc_q   <= in_pc;
                skid_data_q <= in_data;
                skid_ctrl_q <= in_ctrl;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign occupancy = occ_q;
    assign stall_cnt = cnt_q;
    assign out_pc    = main_pc_q;
    assign out_data  = main_data_q;
    assign out_ctrl  = main_ctrl_q;

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Directed bench for pipe_stage_buffer: vector table for streaming/skid, hand sequences for flush and saturation.
module tb_pipe_stage_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, flush, stall_clr;
    logic [31:0] in_pc, out_pc;
    logic [63:0] in_data, out_data;
    logic [8:0]  in_ctrl, out_ctrl;
    logic [1:0]  occupancy;
    logic [3:0]  stall_cnt;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    pipe_stage_buffer #(.PC_W(32), .DATA_W(64), .CTRL_W(9), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_data(out_data), .out_ctrl(out_ctrl),
        .flush(flush), .stall_clr(stall_clr),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic        v, r, fl, clr;
        logic [31:0] pc;
        logic [63:0] data;
        logic [8:0]  ctrl;
        logic        e_v, e_r;
        logic [1:0]  e_occ;
        logic [31:0] e_pc;
        logic [63:0] e_data;
        logic [8:0]  e_ctrl;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic drive(input logic v, input logic r, input logic fl, input logic clr,
                         input logic [31:0] pc, input logic [63:0] data, input logic [8:0] ctrl);
        in_valid = v; out_ready = r; flush = fl; stall_clr = clr;
        in_pc = pc; in_data = data; in_ctrl = ctrl;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic v, input logic r, input logic fl, input logic clr,
                                input logic [31:0] pc, input logic [63:0] data, input logic [8:0] ctrl,
                                input logic e_v, input logic e_r, input logic [1:0] e_occ,
                                input logic [31:0] e_pc, input logic [63:0] e_data,
                                input logic [8:0] e_ctrl, input logic [3:0] e_cnt);
        vec_t t;
        t.v = v; t.r = r; t.fl = fl; t.clr = clr;
        t.pc = pc; t.data = data; t.ctrl = ctrl;
        t.e_v = e_v; t.e_r = e_r; t.e_occ = e_occ;
        t.e_pc = e_pc; t.e_data = e_data; t.e_ctrl = e_ctrl; t.e_cnt = e_cnt;
        return t;
    endfunction

    localparam logic [31:0] PA = 32'h0040_0100, PB = 32'h0040_0104, PC_ = 32'h0040_0108;

    initial begin
        logic [31:0] p;
        logic [63:0] d;

        // Reset held with random inputs
        rst = 1'b0;
        drive($urandom_range(0,1), $urandom_range(0,1), $urandom_range(0,1), $urandom_range(0,1),
              $urandom, {$urandom, $urandom}, 9'($urandom));
        repeat (3) tick();
        chk("rst in_ready",  {63'd0, in_ready}, 64'd1);
        chk("rst out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst out_ctrl",  {55'd0, out_ctrl}, 64'd0);
        chk("rst out_pc",    {32'd0, out_pc}, 64'd0);
        chk("rst occupancy", {62'd0, occupancy}, 64'd0);
        chk("rst stall_cnt", {60'd0, stall_cnt}, 64'd0);
        drive(0, 1, 0, 0, 0, 0, 0);
        rst = 1'b1;

        // Streaming: 8 entries, one per cycle, each visible right after its accept edge
        for (int k = 0; k < 8; k++) begin
            p = 32'h0040_0000 + 32'(4 * k);
            d = (k == 0) ? 64'h2008_0005 : 64'h1000 + 64'(k);
            tbl.push_back(mk(1, 1, 0, 0, p, d, 9'(k + 1), 1, 1, 2'd1, p, d, 9'(k + 1), 4'd0));
        end
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 2'd0, 0, 0, 0, 4'd0));
        // Skid: A, B (out_ready drops), C waits three cycles, then drains in order
        tbl.push_back(mk(1, 1, 0, 0, PA,  64'hA, 9'h001, 1, 1, 2'd1, PA, 64'hA, 9'h001, 4'd0));
        tbl.push_back(mk(1, 0, 0, 0, PB,  64'hB, 9'h002, 1, 0, 2'd2, PA, 64'hA, 9'h001, 4'd0));
        tbl.push_back(mk(1, 0, 0, 0, PC_, 64'hC, 9'h004, 1, 0, 2'd2, PA, 64'hA, 9'h001, 4'd1));
        tbl.push_back(mk(1, 0, 0, 0, PC_, 64'hC, 9'h004, 1, 0, 2'd2, PA, 64'hA, 9'h001, 4'd2));
        tbl.push_back(mk(1, 1, 0, 0, PC_, 64'hC, 9'h004, 1, 1, 2'd1, PB, 64'hB, 9'h002, 4'd3));
        tbl.push_back(mk(1, 1, 0, 0, PC_, 64'hC, 9'h004, 1, 1, 2'd1, PC_, 64'hC, 9'h004, 4'd3));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 2'd0, 0, 0, 0, 4'd3));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 1, 2'd0, 0, 0, 0, 4'd0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].v, tbl[i].r, tbl[i].fl, tbl[i].clr, tbl[i].pc, tbl[i].data, tbl[i].ctrl);
            tick();
            chk($sformatf("v%0d out_valid", i), {63'd0, out_valid}, {63'd0, tbl[i].e_v});
            chk($sformatf("v%0d in_ready", i),  {63'd0, in_ready},  {63'd0, tbl[i].e_r});
            chk($sformatf("v%0d occupancy", i), {62'd0, occupancy}, {62'd0, tbl[i].e_occ});
            chk($sformatf("v%0d out_pc", i),    {32'd0, out_pc},    {32'd0, tbl[i].e_pc});
            chk($sformatf("v%0d out_data", i),  out_data,           tbl[i].e_data);
            chk($sformatf("v%0d out_ctrl", i),  {55'd0, out_ctrl},  {55'd0, tbl[i].e_ctrl});
            chk($sformatf("v%0d stall_cnt", i), {60'd0, stall_cnt}, {60'd0, tbl[i].e_cnt});
        end

        // Flush while FULL with entry D presented
        drive(1, 0, 0, 0, PA, 64'hA, 9'h001); tick();
        drive(1, 0, 0, 0, PB, 64'hB, 9'h002); tick();
        chk("pre-flush occupancy", {62'd0, occupancy}, 64'd2);
        drive(1, 0, 1, 0, 32'h0040_0DDD, 64'hD, 9'h1FF); tick();
        chk("flush occupancy", {62'd0, occupancy}, 64'd0);
        chk("flush out_valid", {63'd0, out_valid}, 64'd0);
        chk("flush in_ready",  {63'd0, in_ready}, 64'd1);
        chk("flush out_pc",    {32'd0, out_pc}, 64'd0);
        chk("flush out_data",  out_data, 64'd0);
        chk("flush out_ctrl",  {55'd0, out_ctrl}, 64'd0);
        chk("flush stall_cnt", {60'd0, stall_cnt}, 64'd0);
        drive(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("post-flush%0d out_valid", i), {63'd0, out_valid}, 64'd0);
            chk($sformatf("post-flush%0d out_pc", i), {32'd0, out_pc}, 64'd0);
        end

        // Saturation: hold FULL with in_valid for 20 cycles
        drive(1, 0, 0, 0, PA, 64'hA, 9'h001); tick();
        drive(1, 0, 0, 0, PB, 64'hB, 9'h002); tick();
        drive(1, 0, 0, 0, PC_, 64'hC, 9'h004);
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk($sformatf("sat%0d stall_cnt", i), {60'd0, stall_cnt}, 64'((i > 15) ? 15 : i));
        end
        chk("sat out_pc held", {32'd0, out_pc}, {32'd0, PA});
        stall_clr = 1'b1; tick();
        chk("clr at sat", {60'd0, stall_cnt}, 64'd0);
        stall_clr = 1'b0; tick();
        chk("count after clr", {60'd0, stall_cnt}, 64'd1);
        stall_clr = 1'b1; tick();
        chk("clr beats inc", {60'd0, stall_cnt}, 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buffer.md
# pipe_stage_buffer

Parametrised pipeline-stage register with a valid/ready handshake, a two-entry skid buffer, synchronous flush and a saturating stall counter. It replaces the fixed-width, always-advancing IF/ID and ID/EX pipeline registers of the MIPS core. One instance is placed per stage boundary. Each instance carries a PC, a data payload and a control bundle, can hold its contents under back-pressure, and can be squashed on a branch or hazard.

## Interface
Parameters:
- PC_W, 32, program-counter width
- DATA_W, 64, payload width (instruction, operands, immediate, register numbers as packed by the instantiating stage)
- CTRL_W, 9, control-bundle width (ALUOp, ALUSrc, RegDst, Branch, MemRead, MemWrite, RegWrite, MemtoReg, PCSrc)
- CNT_W, 16, stall-counter width

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset; asynchronous and active-low (rst=0 resets)
- in_valid  in  1  upstream stage presents an entry
- in_ready  out  1  buffer can accept; registered output
- in_pc  in  PC_W  upstream PC
- in_data  in  DATA_W  upstream payload
- in_ctrl  in  CTRL_W  upstream control bundle
- out_valid  out  1  downstream entry valid; registered output
- out_ready  in  1  downstream stage consumes this cycle
- out_pc  out  PC_W  head PC
- out_data  out  DATA_W  head payload
- out_ctrl  out  CTRL_W  head control bundle
- flush  in  1  synchronous squash of all held entries
- stall_clr  in  1  synchronous clear of stall_cnt
- occupancy  out  2  entries held (0, 1 or 2)
- stall_cnt  out  CNT_W  cycles spent with upstream blocked, saturating

## Operation
Handshake definitions:
- accept = in_valid & in_ready
- deliver = out_valid & out_ready

Storage:
- main register: drives the out_* ports
- skid register: second entry

State machine:
- EMPTY: occupancy=0, out_valid=0, in_ready=1
  - accept → ONE, with main←in
- ONE: occupancy=1, out_valid=1, in_ready=1
  - accept & deliver → ONE, with main←in
  - accept & !deliver → FULL, with skid←in
  - !accept & deliver → EMPTY
  - neither → hold
- FULL: occupancy=2, out_valid=1, in_ready=0
  - deliver → ONE, with main←skid
  - otherwise hold. No accept is possible in FULL.

Rules:
- Order is strictly FIFO. No entry is duplicated or lost except by flush.
- Bubble: whenever the next state is EMPTY, main pc/data/ctrl are loaded with all-zeros. A non-valid output is therefore the MIPS NOP (0x00000000) with all control deasserted.
- flush has priority over every transition:
  - next state is EMPTY and main/skid are zeroed
  - an entry presented in the flush cycle is dropped, even though in_ready=1
  - a deliver in the flush cycle still counts as consumed downstream
- out_* are stable while out_valid=1 and out_ready=0.
- stall_cnt:
  - +1 on each cycle with in_valid=1 & in_ready=0 & flush=0
  - saturates at 2^CNT_W−1 and does not wrap
  - stall_clr zeroes it; stall_clr wins over an increment in the same cycle
- Upstream may drop in_valid without handshake; no entry is recorded.

## Timing
- Reset values (async, on rst=0): state EMPTY, in_ready=1, out_valid=0, out_pc/out_data/out_ctrl=0, occupancy=0, stall_cnt=0. Skid contents are zeroed.
- Latency: accept in cycle N while EMPTY → out_valid=1 with that entry in N+1.
- Throughput: one entry per cycle while out_ready stays high.
- in_ready, out_valid and occupancy are pure register outputs. There is no combinational path from out_ready to in_ready.
- Back-pressure: out_ready falling while ONE with accept absorbs exactly one more entry into skid, then in_ready=0 from the next cycle.
- Flush asserted in cycle N → out_valid=0, in_ready=1, occupancy=0 in N+1.
- Reset deasserted mid-stream: the first accept is possible on the first rising edge after rst returns high.

## Test plan
- Reset: hold rst=0 with random inputs → in_ready=1, out_valid=0, out_ctrl=0, occupancy=0, stall_cnt=0. Release rst, push pc=0x00400000, data=0x20080005 → appears on out_* one cycle later with out_valid=1.
- Streaming: out_ready=1, push 8 consecutive entries pc=0x00400000+4k → 8 delivers in order, one per cycle, occupancy never above 1, stall_cnt=0.
- Skid: push A, B, then drop out_ready for 3 cycles while in_valid=1 with C →
  - B lands in skid and occupancy=2
  - in_ready=0 and C is held upstream; stall_cnt rises by 1 for each cycle C waits (first count in the cycle after B enters skid)
  - on out_ready=1 the output is A, B, C in order, with no loss
- Flush: with occupancy=2 and in_valid=1 (entry D), assert flush one cycle → next cycle occupancy=0, out_valid=0, out_pc/out_data/out_ctrl=0. D never appears at the output.
- Simultaneous events in ONE: accept & deliver in the same cycle → occupancy stays 1 and out_* switch to the new entry. In FULL with in_valid=1 & out_ready=1 → only the skid entry moves to main; occupancy becomes 1.
- Counter: CNT_W=4, hold FULL with in_valid=1 for 20 cycles → stall_cnt saturates at 15. stall_clr together with an increment condition → 0 next cycle.
